// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: round-robin arbiter sharing one memory controller among NUM_REQ requesters
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   req_valid/req_rdy          per-requester request handshake (req_rdy is a one-hot accept pulse)
//   req_we/req_addr/req_wdata  packed per-requester request fields
//   resp_valid/resp_data       one-hot completion pulse, read data held until the next pulse
//   grant_id, busy             current/last winner, transaction in progress
//   mc_*                       memory controller request/response and reported controller state
//   wdog_err                   sticky watchdog error (only when MC_ARB_WATCHDOG_EN is defined, else 0)
module mem_req_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int STATE_W     = 5,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_rdy,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic [DATA_W-1:0]         resp_data,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                      busy,
    output logic                      mc_rd_en,
    output logic                      mc_wr_en,
    output logic [ADDR_W-1:0]         mc_addr,
    output logic [DATA_W-1:0]         mc_wdata,
    output logic                      mc_request_valid,
    input  logic                      mc_request_rdy,
    input  logic                      mc_done,
    input  logic [DATA_W-1:0]         mc_data,
    input  logic [STATE_W-1:0]        mc_state,
    output logic                      wdog_err
);
    localparam int GW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 16 || WDOG_CYCLES < 1) begin : g_bad_param
        $error("mem_req_arbiter: parameter out of range");
    end

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_CONFIRM, S_RETRY, S_WAIT, S_DRAIN} state_t;
    state_t state, state_nx;
    logic [GW-1:0] last_grant, grant_q, winner, cand;
    logic [NUM_REQ-1:0] resp_q;
    logic we_q, mc_idle, accept, mc_took;

    assign mc_idle = mc_state == '0 && mc_request_rdy;
    assign mc_took = mc_state == STATE_W'(2) || mc_state == STATE_W'(3);
    assign accept = state == S_IDLE && |req_valid && mc_idle;

    // Scan from farthest to nearest so the first valid index after last_grant wins.
    always_comb begin
        winner = '0;
        cand = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = GW'((int'(last_grant) + k) % NUM_REQ);
            if (req_valid[cand]) winner = cand;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    state_nx = accept ? S_ISSUE : S_IDLE;
            S_ISSUE:   state_nx = S_CONFIRM;
            S_CONFIRM: state_nx = mc_took ? S_WAIT : S_RETRY;
            S_RETRY:   state_nx = mc_idle ? S_ISSUE : S_RETRY;
            S_WAIT:    state_nx = mc_done ? S_DRAIN : S_WAIT;
            S_DRAIN:   state_nx = !mc_done && mc_state == '0 ? S_IDLE : S_DRAIN;
            default:   state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        req_rdy = accept && !rst ? NUM_REQ'(1) << winner : '0;
        busy = state != S_IDLE;
        mc_request_valid = state == S_ISSUE;
        mc_rd_en = state == S_ISSUE && !we_q;
        mc_wr_en = state == S_ISSUE && we_q;
        resp_valid = resp_q;
        grant_id = grant_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= GW'(NUM_REQ - 1);
            grant_q <= '0;
            we_q <= 1'b0;
            mc_addr <= '0;
            mc_wdata <= '0;
            resp_q <= '0;
            resp_data <= '0;
        end else begin
            resp_q <= '0;
            if (accept) begin
                grant_q <= winner;
                we_q <= req_we[winner];
                mc_addr <= req_addr[int'(winner)*ADDR_W +: ADDR_W];
                mc_wdata <= req_wdata[int'(winner)*DATA_W +: DATA_W];
            end
            if (state == S_WAIT && mc_done) begin
                resp_q <= NUM_REQ'(1) << grant_q;
                resp_data <= mc_data;
            end
            if (state == S_DRAIN && state_nx == S_IDLE) last_grant <= grant_q;
        end
    end

`ifdef MC_ARB_WATCHDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES + 1);
    logic [WW-1:0] wdog_cnt;
    logic wdog_q;
    // Cleared while issuing so every entry to S_CONFIRM starts from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_cnt <= '0;
            wdog_q <= 1'b0;
        end else if (state == S_ISSUE) begin
            wdog_cnt <= '0;
        end else if (state != S_IDLE && !wdog_q) begin
            wdog_cnt <= wdog_cnt + 1'b1;
            if (wdog_cnt == WW'(WDOG_CYCLES - 1)) wdog_q <= 1'b1;
        end
    end
    assign wdog_err = wdog_q;
`else
    assign wdog_err = 1'b0;
`endif
endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: randomized self-checking bench with a round-robin reference model
module tb_mem_req_arbiter;
    localparam int N = 4, AW = 32, DW = 32, SW = 5, WD = 64;
`ifdef MC_ARB_WATCHDOG_EN
    localparam bit WD_ON = 1'b1;
`else
    localparam bit WD_ON = 1'b0;
`endif
    logic clk = 1'b0, rst;
    logic [N-1:0] req_valid, req_rdy, req_we, resp_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [DW-1:0] resp_data, mc_wdata, mc_data;
    logic [AW-1:0] mc_addr;
    logic [$clog2(N)-1:0] grant_id;
    logic busy, mc_rd_en, mc_wr_en, mc_request_valid, mc_request_rdy, mc_done, wdog_err;
    logic [SW-1:0] mc_state;

    mem_req_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .STATE_W(SW), .WDOG_CYCLES(WD)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_rdy(req_rdy), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_data(resp_data),
        .grant_id(grant_id), .busy(busy), .mc_rd_en(mc_rd_en), .mc_wr_en(mc_wr_en),
        .mc_addr(mc_addr), .mc_wdata(mc_wdata), .mc_request_valid(mc_request_valid),
        .mc_request_rdy(mc_request_rdy), .mc_done(mc_done), .mc_data(mc_data),
        .mc_state(mc_state), .wdog_err(wdog_err)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int last_g = N - 1;
    logic [AW-1:0] a [N];
    logic [DW-1:0] d [N];
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wd;
    bit exp_we;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Round-robin rule: first valid requester after the last winner, wrapping around.
    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    task automatic start_txn(input logic [N-1:0] mask, output int g);
        for (int i = 0; i < N; i++) begin
            a[i] = $urandom;
            d[i] = $urandom;
            req_addr[i*AW +: AW] = a[i];
            req_wdata[i*DW +: DW] = d[i];
        end
        req_we = N'($urandom);
        req_valid = mask;
        #1;
        g = rr_pick(mask, last_g);
        check("req_rdy", req_rdy, 64'(1) << g);
        exp_addr = a[g];
        exp_wd = d[g];
        exp_we = req_we[g];
        @(negedge clk);
        req_valid = '0;
        check("issue_valid", mc_request_valid, 1);
        check("rd_en", mc_rd_en, !exp_we);
        check("wr_en", mc_wr_en, exp_we);
        check("mc_addr", mc_addr, exp_addr);
        check("mc_wdata", mc_wdata, exp_wd);
        check("grant_id", grant_id, g);
        check("busy", busy, 1);
        check("rdy_pulse", req_rdy, 0);
    endtask

    task automatic finish_txn(input int g, input bit refresh, input int wait_cyc, input int hold);
        bit ok;
        logic [DW-1:0] rd;
        mc_state = refresh ? SW'(6) : (exp_we ? SW'(3) : SW'(2));
        mc_request_rdy = !refresh;
        @(negedge clk);
        check("issue_once", mc_request_valid, 0);
        if (refresh) begin
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                check("retry_quiet", mc_request_valid, 0);
            end
            mc_state = '0;
            mc_request_rdy = 1'b1;
            ok = 1'b0;
            for (int k = 0; k < 8 && !ok; k++) begin
                @(negedge clk);
                ok = mc_request_valid;
            end
            check("reissue", ok, 1);
            check("reissue_addr", mc_addr, exp_addr);
            check("reissue_wr", mc_wr_en, exp_we);
            check("refresh_resp", resp_valid, 0);
            mc_state = exp_we ? SW'(3) : SW'(2);
            @(negedge clk);
            check("reissue_once", mc_request_valid, 0);
        end
        repeat (wait_cyc) begin
            @(negedge clk);
            check("early_resp", resp_valid, 0);
        end
        mc_done = 1'b1;
        mc_data = $urandom;
        rd = mc_data;
        mc_state = SW'(5);
        @(negedge clk);
        check("resp_valid", resp_valid, 64'(1) << g);
        check("resp_data", resp_data, rd);
        check("addr_stable", mc_addr, exp_addr);
        check("wdata_stable", mc_wdata, exp_wd);
        mc_data = $urandom;
        repeat (hold) begin
            @(negedge clk);
            check("single_resp", resp_valid, 0);
            check("drain_busy", busy, 1);
        end
        mc_done = 1'b0;
        mc_state = '0;
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("resp_hold", resp_data, rd);
        check("resp_clear", resp_valid, 0);
        last_g = g;
    endtask

    initial begin
        int g;
        rst = 1'b1;
        req_valid = '1;
        req_we = '0;
        req_addr = '0;
        req_wdata = '0;
        mc_request_rdy = 1'b1;
        mc_done = 1'b0;
        mc_data = '0;
        mc_state = '0;
        repeat (3) @(negedge clk);
        check("rst_rdy", req_rdy, 0);
        check("rst_busy", busy, 0);
        check("rst_issue", mc_request_valid, 0);
        check("rst_addr", mc_addr, 0);
        check("rst_resp", resp_valid, 0);
        check("rst_grant", grant_id, 0);
        check("rst_wdog", wdog_err, 0);
        rst = 1'b0;
        req_valid = 4'b0001;
        mc_state = SW'(6);
        #1 check("no_accept_refresh", req_rdy, 0);
        mc_state = '0;
        mc_request_rdy = 1'b0;
        #1 check("no_accept_notrdy", req_rdy, 0);
        @(negedge clk);
        check("stay_idle", busy, 0);
        req_valid = '0;
        mc_request_rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            start_txn(4'b1111, g);
            finish_txn(g, 1'b0, 1, 0);
        end
        start_txn(4'b0010, g);
        finish_txn(g, 1'b1, 2, 1);
        for (int i = 0; i < 40; i++) begin
            start_txn(N'($urandom_range(1, (1 << N) - 1)), g);
            finish_txn(g, $urandom_range(0, 3) == 0, $urandom_range(1, 4), $urandom_range(0, 2));
        end
        start_txn(4'b1111, g);
        mc_state = SW'(2);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        req_valid = '1;
        mc_state = '0;
        @(negedge clk);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_issue", mc_request_valid, 0);
        check("mid_rst_addr", mc_addr, 0);
        check("mid_rst_rdy", req_rdy, 0);
        rst = 1'b0;
        req_valid = '0;
        last_g = N - 1;
        start_txn(4'b1111, g);
        finish_txn(g, 1'b0, 2, 0);
        start_txn(N'($urandom_range(1, (1 << N) - 1)), g);
        mc_state = SW'(2);
        @(negedge clk);
        for (int k = 1; k <= 66; k++) begin
            @(negedge clk);
            if (k == 63) check("wdog_early", wdog_err, 0);
            if (k == 64) check("wdog_fire", wdog_err, WD_ON);
        end
        check("wdog_sticky", wdog_err, WD_ON);
        check("wdog_fsm_wait", busy, 1);
        rst = 1'b1;
        mc_state = '0;
        @(negedge clk);
        rst = 1'b0;
        check("wdog_rst", wdog_err, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
